lag_sweep_scheduler: RTL and testbench



---
 rtl/lag_sweep_pkg.sv | 21 ++
 rtl/lag_step_alu.sv | 31 +++
 rtl/lag_sweep_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_lag_sweep_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lag_sweep_pkg.sv
// Shared types and constants for the lag-sweep scheduler: walk FSM states,
// configuration-select encodings and default widths.
package lag_sweep_pkg;

  localparam int unsigned DefNumInputs  = 8;
  localparam int unsigned DefDelayWidth = 20;
  localparam int unsigned DefIncWidth   = 12;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStep,
    StDone
  } state_e;

  localparam logic [1:0] CFG_START = 2'd0;
  localparam logic [1:0] CFG_LEN   = 2'd1;
  localparam logic [1:0] CFG_INC   = 2'd2;
  localparam logic [1:0] CFG_CLR   = 2'd3;

endpackage

// File: rtl/lag_step_alu.sv
// Shared next-lag computation: advance by inc while below start+len and the
// sum fits in DELAY_WIDTH bits, otherwise reload start.
module lag_step_alu
  import lag_sweep_pkg::*;
#(
  parameter int unsigned DELAY_WIDTH = DefDelayWidth,
  parameter int unsigned INC_WIDTH   = DefIncWidth
) (
  input  logic [DELAY_WIDTH-1:0] i_start,
  input  logic [DELAY_WIDTH-1:0] i_len,
  input  logic [DELAY_WIDTH-1:0] i_cur,
  input  logic [INC_WIDTH-1:0]   i_inc,
  input  logic                   i_en,
  output logic [DELAY_WIDTH-1:0] o_next,
  output logic                   o_wrap
);

  logic [DELAY_WIDTH:0] w_limit;
  logic [DELAY_WIDTH:0] w_sum;
  logic                 w_adv;

  always_comb begin
    w_limit = {1'b0, i_start} + {1'b0, i_len};
    w_sum   = {1'b0, i_cur} + {{(DELAY_WIDTH + 1 - INC_WIDTH){1'b0}}, i_inc};
    // Carry out of the sum means saturation: reload rather than wrap modulo.
    w_adv   = i_en && ({1'b0, i_cur} < w_limit) && !w_sum[DELAY_WIDTH];
    o_next  = w_adv ? w_sum[DELAY_WIDTH-1:0] : i_start;
    o_wrap  = i_en && !w_adv;
  end

endmodule

// File: rtl/lag_sweep_scheduler.sv
// Per-channel lag sweep sequencer; one shared step ALU walked round-robin per frame.
// Optional LAG_SWEEP_WRAP_IRQ_EN enables the per-channel sweep_wrap pulse.
module lag_sweep_scheduler
  import lag_sweep_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = DefNumInputs,
  parameter int unsigned DELAY_WIDTH = DefDelayWidth,
  parameter int unsigned INC_WIDTH   = DefIncWidth
) (
  input  logic                              pllclk,
  input  logic                              reset,
  input  logic                              cfg_we,
  input  logic [7:0]                        cfg_channel,
  input  logic [1:0]                        cfg_sel,
  input  logic [DELAY_WIDTH-1:0]            cfg_data,
  input  logic [NUM_INPUTS-1:0]             sweep_en,
  input  logic                              frame_tick,
  output logic [NUM_INPUTS*DELAY_WIDTH-1:0] delay_out,
  output logic                              busy,
  output logic [NUM_INPUTS-1:0]             sweep_wrap,
  output logic                              frame_overrun
);

  localparam int unsigned ChW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [ChW-1:0] LastCh = ChW'(NUM_INPUTS - 1);
  localparam logic [7:0] NumCh = 8'(NUM_INPUTS);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [ChW-1:0]         r_ch;
  logic [ChW-1:0]         w_ch_nxt;
  logic                   w_fetch;
  logic                   w_step;

  logic [DELAY_WIDTH-1:0] r_start [NUM_INPUTS];
  logic [DELAY_WIDTH-1:0] r_len   [NUM_INPUTS];
  logic [INC_WIDTH-1:0]   r_inc   [NUM_INPUTS];
  logic [DELAY_WIDTH-1:0] r_cur   [NUM_INPUTS];

  logic [DELAY_WIDTH-1:0] r_op_start;
  logic [DELAY_WIDTH-1:0] r_op_len;
  logic [DELAY_WIDTH-1:0] r_op_cur;
  logic [INC_WIDTH-1:0]   r_op_inc;
  logic                   r_op_en;

  logic [DELAY_WIDTH-1:0] w_alu_next;
  logic                   w_alu_wrap;
  logic                   w_cfg_hit;
  logic [ChW-1:0]         w_cfg_idx;
  logic                   r_overrun;

  assign w_cfg_hit = cfg_we && (cfg_channel < NumCh);
  assign w_cfg_idx = cfg_channel[ChW-1:0];

  always_ff @(posedge pllclk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_fetch     = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (frame_tick) begin
          w_state_nxt = StFetch;
          w_ch_nxt    = '0;
        end
      end
      StFetch: begin
        w_fetch     = 1'b1;
        w_state_nxt = StStep;
      end
      StStep: begin
        w_step = 1'b1;
        if (r_ch == LastCh) begin
          w_state_nxt = StDone;
        end else begin
          w_ch_nxt    = r_ch + 1'b1;
          w_state_nxt = StFetch;
        end
      end
      StDone: w_state_nxt = StIdle;
    endcase
  end

  assign busy = (r_state != StIdle);

  always_ff @(posedge pllclk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_INPUTS; c++) begin
        r_start[c] <= '0;
        r_len[c]   <= '0;
        r_inc[c]   <= '0;
      end
    end else if (w_cfg_hit) begin
      unique case (cfg_sel)
        CFG_START: r_start[w_cfg_idx] <= cfg_data;
        CFG_LEN:   r_len[w_cfg_idx]   <= cfg_data;
        CFG_INC:   r_inc[w_cfg_idx]   <= cfg_data[INC_WIDTH-1:0];
        CFG_CLR:   ;
      endcase
    end
  end

  // Operands are frozen here so a config write during FETCH/STEP lands next frame.
  always_ff @(posedge pllclk or posedge reset) begin
    if (reset) begin
      r_op_start <= '0;
      r_op_len   <= '0;
      r_op_inc   <= '0;
      r_op_cur   <= '0;
      r_op_en    <= 1'b0;
    end else if (w_fetch) begin
      r_op_start <= r_start[r_ch];
      r_op_len   <= r_len[r_ch];
      r_op_inc   <= r_inc[r_ch];
      r_op_cur   <= r_cur[r_ch];
      r_op_en    <= sweep_en[r_ch];
    end
  end

  lag_step_alu #(
    .DELAY_WIDTH (DELAY_WIDTH),
    .INC_WIDTH   (INC_WIDTH)
  ) u_alu (
    .i_start (r_op_start),
    .i_len   (r_op_len),
    .i_cur   (r_op_cur),
    .i_inc   (r_op_inc),
    .i_en    (r_op_en),
    .o_next  (w_alu_next),
    .o_wrap  (w_alu_wrap)
  );

  always_ff @(posedge pllclk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_INPUTS; c++) begin
        r_cur[c] <= '0;
      end
    end else if (w_step) begin
      r_cur[r_ch] <= w_alu_next;
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_out
    assign delay_out[g*DELAY_WIDTH +: DELAY_WIDTH] = r_cur[g];
  end

  // A new overrun outranks a same-cycle clear.
  always_ff @(posedge pllclk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (frame_tick && busy) begin
      r_overrun <= 1'b1;
    end else if (w_cfg_hit && (cfg_sel == CFG_CLR)) begin
      r_overrun <= 1'b0;
    end
  end

  assign frame_overrun = r_overrun;

`ifdef LAG_SWEEP_WRAP_IRQ_EN
  logic [NUM_INPUTS-1:0] r_wrap;
  logic [NUM_INPUTS-1:0] w_wrap_nxt;

  always_comb begin
    w_wrap_nxt = '0;
    if (w_step) w_wrap_nxt[r_ch] = w_alu_wrap;
  end

  always_ff @(posedge pllclk or posedge reset) begin
    if (reset) r_wrap <= '0;
    else       r_wrap <= w_wrap_nxt;
  end

  assign sweep_wrap = r_wrap;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = w_alu_wrap;
  assign sweep_wrap    = '0;
`endif

endmodule

// File: tb/tb_lag_sweep_scheduler.sv
// Self-checking bench for lag_sweep_scheduler: directed scenarios plus randomized
// configurations checked cycle by cycle against an arithmetic per-frame model.
module tb_lag_sweep_scheduler;
  localparam int NI = 8;
  localparam int DW = 20;
  localparam int IW = 12;
  localparam longint MaxVal = (longint'(1) << DW) - 1;

  logic             pllclk;
  logic             reset;
  logic             cfg_we;
  logic [7:0]       cfg_channel;
  logic [1:0]       cfg_sel;
  logic [DW-1:0]    cfg_data;
  logic [NI-1:0]    sweep_en;
  logic             frame_tick;
  logic [NI*DW-1:0] delay_out;
  logic             busy;
  logic [NI-1:0]    sweep_wrap;
  logic             frame_overrun;

  int n_chk = 0;
  int n_err = 0;

  longint m_start [NI];
  longint m_len   [NI];
  longint m_inc   [NI];
  longint m_cur   [NI];
  bit     m_ovr;

  lag_sweep_scheduler #(
    .NUM_INPUTS  (NI),
    .DELAY_WIDTH (DW),
    .INC_WIDTH   (IW)
  ) dut (
    .pllclk        (pllclk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_channel   (cfg_channel),
    .cfg_sel       (cfg_sel),
    .cfg_data      (cfg_data),
    .sweep_en      (sweep_en),
    .frame_tick    (frame_tick),
    .delay_out     (delay_out),
    .busy          (busy),
    .sweep_wrap    (sweep_wrap),
    .frame_overrun (frame_overrun)
  );

  initial begin
    pllclk = 1'b0;
    forever #5 pllclk = ~pllclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge pllclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NI*DW-1:0] got,
                     input logic [NI*DW-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void mdl_clear();
    for (int c = 0; c < NI; c++) begin
      m_start[c] = 0;
      m_len[c]   = 0;
      m_inc[c]   = 0;
      m_cur[c]   = 0;
    end
    m_ovr = 0;
  endfunction

  task automatic cfg_wr(input int ch, input int sel, input longint data);
    cfg_we      = 1'b1;
    cfg_channel = 8'(ch);
    cfg_sel     = 2'(sel);
    cfg_data    = DW'(data);
    step();
    cfg_we = 1'b0;
    if (ch < NI) begin
      case (sel)
        0: m_start[ch] = data & MaxVal;
        1: m_len[ch]   = data & MaxVal;
        2: m_inc[ch]   = data & ((longint'(1) << IW) - 1);
        default: m_ovr = 0;
      endcase
    end
  endtask

  // One full walk. ovr_edge > 0 re-pulses frame_tick so it is sampled on that edge;
  // wr_edge > 0 writes start of wr_ch on that edge (channel must already be fetched).
  task automatic run_frame(input logic [NI-1:0] en, input int ovr_edge, input int wr_edge,
                           input int wr_ch, input longint wr_data,
                           output logic [NI-1:0] seen);
    longint           nxt [NI];
    bit               wr  [NI];
    logic [NI*DW-1:0] ev;
    logic [NI-1:0]    ew;
    seen = '0;
    for (int c = 0; c < NI; c++) begin
      if (en[c] && m_cur[c] < m_start[c] + m_len[c] && m_cur[c] + m_inc[c] <= MaxVal) begin
        nxt[c] = m_cur[c] + m_inc[c];
        wr[c]  = 0;
      end else begin
        nxt[c] = m_start[c];
        wr[c]  = en[c];
      end
    end
    sweep_en   = en;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 0; k <= 2 * NI + 1; k++) begin
      if (k > 0) step();
      if (ovr_edge > 0 && k >= ovr_edge) m_ovr = 1;
      for (int c = 0; c < NI; c++) ev[c*DW +: DW] = DW'((k >= 2 * c + 2) ? nxt[c] : m_cur[c]);
      ew = '0;
`ifdef LAG_SWEEP_WRAP_IRQ_EN
      if (k >= 2 && k % 2 == 0 && k <= 2 * NI) ew[(k-2)/2] = wr[(k-2)/2];
`endif
      seen |= sweep_wrap;
      chk($sformatf("busy_k%0d", k), {{(NI*DW-1){1'b0}}, busy}, {{(NI*DW-1){1'b0}}, (k <= 2 * NI)});
      chk($sformatf("delay_k%0d", k), delay_out, ev);
      chk($sformatf("wrap_k%0d", k), {{(NI*DW-NI){1'b0}}, sweep_wrap}, {{(NI*DW-NI){1'b0}}, ew});
      chk($sformatf("ovr_k%0d", k), {{(NI*DW-1){1'b0}}, frame_overrun},
          {{(NI*DW-1){1'b0}}, m_ovr});
      frame_tick = (k + 1 == ovr_edge);
      if (k + 1 == wr_edge) begin
        cfg_we      = 1'b1;
        cfg_channel = 8'(wr_ch);
        cfg_sel     = 2'd0;
        cfg_data    = DW'(wr_data);
      end else begin
        cfg_we = 1'b0;
      end
    end
    frame_tick = 1'b0;
    cfg_we     = 1'b0;
    for (int c = 0; c < NI; c++) m_cur[c] = nxt[c];
    if (wr_edge > 0) m_start[wr_ch] = wr_data & MaxVal;
  endtask

  initial begin
    logic [NI-1:0] seen;
    logic [DW-1:0] d_tab [6];
    logic [NI-1:0] en_r;
    int            ovr_r;
    longint        v;
    d_tab[0] = 20'd5; d_tab[1] = 20'd6; d_tab[2] = 20'd7;
    d_tab[3] = 20'd4; d_tab[4] = 20'd5; d_tab[5] = 20'd6;

    reset = 1'b1; cfg_we = 1'b0; cfg_channel = '0; cfg_sel = '0; cfg_data = '0;
    sweep_en = '0; frame_tick = 1'b0;
    mdl_clear();
    repeat (3) step();
    chk("rst_delay", delay_out, '0);
    chk("rst_busy", {{(NI*DW-1){1'b0}}, busy}, '0);
    chk("rst_wrap", {{(NI*DW-NI){1'b0}}, sweep_wrap}, '0);
    chk("rst_ovr", {{(NI*DW-1){1'b0}}, frame_overrun}, '0);
    reset = 1'b0;
    step();

    // Basic sweep on channel 0, primed with one disabled frame so cur = start.
    cfg_wr(0, 0, 4); cfg_wr(0, 1, 3); cfg_wr(0, 2, 1);
    run_frame('0, 0, 0, 0, 0, seen);
    chk("basic_prime", {{(NI*DW-DW){1'b0}}, delay_out[DW-1:0]}, {{(NI*DW-DW){1'b0}}, 20'd4});
    for (int f = 0; f < 6; f++) begin
      run_frame(8'h01, 0, 0, 0, 0, seen);
      chk($sformatf("basic_f%0d", f), {{(NI*DW-DW){1'b0}}, delay_out[DW-1:0]},
          {{(NI*DW-DW){1'b0}}, d_tab[f]});
`ifdef LAG_SWEEP_WRAP_IRQ_EN
      chk($sformatf("basic_wrap_f%0d", f), {{(NI*DW-1){1'b0}}, seen[0]},
          {{(NI*DW-1){1'b0}}, (f == 3)});
`endif
    end

    // Disabled channel; new start written while channel 3 is in STEP.
    cfg_wr(3, 0, 10);
    run_frame('0, 0, 8, 3, 20, seen);
    chk("dis_f1", {{(NI*DW-DW){1'b0}}, delay_out[3*DW +: DW]}, {{(NI*DW-DW){1'b0}}, 20'd10});
    run_frame('0, 0, 0, 0, 0, seen);
    chk("dis_f2", {{(NI*DW-DW){1'b0}}, delay_out[3*DW +: DW]}, {{(NI*DW-DW){1'b0}}, 20'd20});

    // Saturation: sum overflows 20 bits, so channel 1 reloads start.
    cfg_wr(1, 0, 'hFFFF0); cfg_wr(1, 1, 'hF); cfg_wr(1, 2, 'hFFF);
    run_frame('0, 0, 0, 0, 0, seen);
    run_frame(8'h02, 0, 0, 0, 0, seen);
    chk("sat_d1", {{(NI*DW-DW){1'b0}}, delay_out[DW +: DW]}, {{(NI*DW-DW){1'b0}}, 20'hFFFF0});
`ifdef LAG_SWEEP_WRAP_IRQ_EN
    chk("sat_wrap", {{(NI*DW-1){1'b0}}, seen[1]}, {{(NI*DW-1){1'b0}}, 1'b1});
`endif

    // Overrun: second tick at edge 5 is ignored but sets the sticky flag.
    run_frame(8'h03, 5, 0, 0, 0, seen);
    chk("ovr_set", {{(NI*DW-1){1'b0}}, frame_overrun}, {{(NI*DW-1){1'b0}}, 1'b1});
    cfg_wr(2, 3, 0);
    chk("ovr_clr", {{(NI*DW-1){1'b0}}, frame_overrun}, '0);

    // Reset seven cycles into a walk.
    sweep_en   = '1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (7) step();
    #3 reset = 1'b1;
    #1;
    chk("midrst_busy", {{(NI*DW-1){1'b0}}, busy}, '0);
    chk("midrst_delay", delay_out, '0);
    chk("midrst_ovr", {{(NI*DW-1){1'b0}}, frame_overrun}, '0);
    step();
    reset = 1'b0;
    mdl_clear();
    step();
    cfg_wr(0, 0, 4); cfg_wr(0, 1, 3); cfg_wr(0, 2, 1);
    run_frame(8'h01, 0, 0, 0, 0, seen);
    chk("post_rst_d0", {{(NI*DW-DW){1'b0}}, delay_out[DW-1:0]}, {{(NI*DW-DW){1'b0}}, 20'd1});

    // Randomized configurations, enables and overruns.
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < NI; c++) begin
        v = ($urandom_range(0, 2) == 0) ? (longint'(1) << DW) - $urandom_range(1, 64)
                                        : longint'($urandom_range(0, 32'hFFFFF));
        cfg_wr(c, 0, v);
        v = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(0, 8))
                                        : longint'($urandom & 32'hFFFFF);
        cfg_wr(c, 1, v);
        v = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(0, 5))
                                        : longint'($urandom & 32'hFFFFF);
        cfg_wr(c, 2, v);
      end
      cfg_wr($urandom_range(NI, 255), $urandom_range(0, 3), longint'($urandom & 32'hFFFFF));
      for (int f = 0; f < 4; f++) begin
        en_r  = NI'($urandom);
        ovr_r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * NI + 1) : 0;
        run_frame(en_r, ovr_r, 0, 0, 0, seen);
        if ($urandom_range(0, 2) == 0) cfg_wr($urandom_range(0, NI - 1), 3, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
